// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encodings and byte/word helpers used by the key
// schedule and the round datapaths.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    case (round)
      4'd1: r = 8'h01;  4'd2: r = 8'h02;  4'd3: r = 8'h04;  4'd4: r = 8'h08;
      4'd5: r = 8'h10;  4'd6: r = 8'h20;  4'd7: r = 8'h40;  4'd8: r = 8'h80;
      4'd9: r = 8'h1b;  4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s=8'h63; 8'h01: s=8'h7c; 8'h02: s=8'h77; 8'h03: s=8'h7b; 8'h04: s=8'hf2; 8'h05: s=8'h6b; 8'h06: s=8'h6f; 8'h07: s=8'hc5;
      8'h08: s=8'h30; 8'h09: s=8'h01; 8'h0a: s=8'h67; 8'h0b: s=8'h2b; 8'h0c: s=8'hfe; 8'h0d: s=8'hd7; 8'h0e: s=8'hab; 8'h0f: s=8'h76;
      8'h10: s=8'hca; 8'h11: s=8'h82; 8'h12: s=8'hc9; 8'h13: s=8'h7d; 8'h14: s=8'hfa; 8'h15: s=8'h59; 8'h16: s=8'h47; 8'h17: s=8'hf0;
      8'h18: s=8'had; 8'h19: s=8'hd4; 8'h1a: s=8'ha2; 8'h1b: s=8'haf; 8'h1c: s=8'h9c; 8'h1d: s=8'ha4; 8'h1e: s=8'h72; 8'h1f: s=8'hc0;
      8'h20: s=8'hb7; 8'h21: s=8'hfd; 8'h22: s=8'h93; 8'h23: s=8'h26; 8'h24: s=8'h36; 8'h25: s=8'h3f; 8'h26: s=8'hf7; 8'h27: s=8'hcc;
      8'h28: s=8'h34; 8'h29: s=8'ha5; 8'h2a: s=8'he5; 8'h2b: s=8'hf1; 8'h2c: s=8'h71; 8'h2d: s=8'hd8; 8'h2e: s=8'h31; 8'h2f: s=8'h15;
      8'h30: s=8'h04; 8'h31: s=8'hc7; 8'h32: s=8'h23; 8'h33: s=8'hc3; 8'h34: s=8'h18; 8'h35: s=8'h96; 8'h36: s=8'h05; 8'h37: s=8'h9a;
      8'h38: s=8'h07; 8'h39: s=8'h12; 8'h3a: s=8'h80; 8'h3b: s=8'he2; 8'h3c: s=8'heb; 8'h3d: s=8'h27; 8'h3e: s=8'hb2; 8'h3f: s=8'h75;
      8'h40: s=8'h09; 8'h41: s=8'h83; 8'h42: s=8'h2c; 8'h43: s=8'h1a; 8'h44: s=8'h1b; 8'h45: s=8'h6e; 8'h46: s=8'h5a; 8'h47: s=8'ha0;
      8'h48: s=8'h52; 8'h49: s=8'h3b; 8'h4a: s=8'hd6; 8'h4b: s=8'hb3; 8'h4c: s=8'h29; 8'h4d: s=8'he3; 8'h4e: s=8'h2f; 8'h4f: s=8'h84;
      8'h50: s=8'h53; 8'h51: s=8'hd1; 8'h52: s=8'h00; 8'h53: s=8'hed; 8'h54: s=8'h20; 8'h55: s=8'hfc; 8'h56: s=8'hb1; 8'h57: s=8'h5b;
      8'h58: s=8'h6a; 8'h59: s=8'hcb; 8'h5a: s=8'hbe; 8'h5b: s=8'h39; 8'h5c: s=8'h4a; 8'h5d: s=8'h4c; 8'h5e: s=8'h58; 8'h5f: s=8'hcf;
      8'h60: s=8'hd0; 8'h61: s=8'hef; 8'h62: s=8'haa; 8'h63: s=8'hfb; 8'h64: s=8'h43; 8'h65: s=8'h4d; 8'h66: s=8'h33; 8'h67: s=8'h85;
      8'h68: s=8'h45; 8'h69: s=8'hf9; 8'h6a: s=8'h02; 8'h6b: s=8'h7f; 8'h6c: s=8'h50; 8'h6d: s=8'h3c; 8'h6e: s=8'h9f; 8'h6f: s=8'ha8;
      8'h70: s=8'h51; 8'h71: s=8'ha3; 8'h72: s=8'h40; 8'h73: s=8'h8f; 8'h74: s=8'h92; 8'h75: s=8'h9d; 8'h76: s=8'h38; 8'h77: s=8'hf5;
      8'h78: s=8'hbc; 8'h79: s=8'hb6; 8'h7a: s=8'hda; 8'h7b: s=8'h21; 8'h7c: s=8'h10; 8'h7d: s=8'hff; 8'h7e: s=8'hf3; 8'h7f: s=8'hd2;
      8'h80: s=8'hcd; 8'h81: s=8'h0c; 8'h82: s=8'h13; 8'h83: s=8'hec; 8'h84: s=8'h5f; 8'h85: s=8'h97; 8'h86: s=8'h44; 8'h87: s=8'h17;
      8'h88: s=8'hc4; 8'h89: s=8'ha7; 8'h8a: s=8'h7e; 8'h8b: s=8'h3d; 8'h8c: s=8'h64; 8'h8d: s=8'h5d; 8'h8e: s=8'h19; 8'h8f: s=8'h73;
      8'h90: s=8'h60; 8'h91: s=8'h81; 8'h92: s=8'h4f; 8'h93: s=8'hdc; 8'h94: s=8'h22; 8'h95: s=8'h2a; 8'h96: s=8'h90; 8'h97: s=8'h88;
      8'h98: s=8'h46; 8'h99: s=8'hee; 8'h9a: s=8'hb8; 8'h9b: s=8'h14; 8'h9c: s=8'hde; 8'h9d: s=8'h5e; 8'h9e: s=8'h0b; 8'h9f: s=8'hdb;
      8'ha0: s=8'he0; 8'ha1: s=8'h32; 8'ha2: s=8'h3a; 8'ha3: s=8'h0a; 8'ha4: s=8'h49; 8'ha5: s=8'h06; 8'ha6: s=8'h24; 8'ha7: s=8'h5c;
      8'ha8: s=8'hc2; 8'ha9: s=8'hd3; 8'haa: s=8'hac; 8'hab: s=8'h62; 8'hac: s=8'h91; 8'had: s=8'h95; 8'hae: s=8'he4; 8'haf: s=8'h79;
      8'hb0: s=8'he7; 8'hb1: s=8'hc8; 8'hb2: s=8'h37; 8'hb3: s=8'h6d; 8'hb4: s=8'h8d; 8'hb5: s=8'hd5; 8'hb6: s=8'h4e; 8'hb7: s=8'ha9;
      8'hb8: s=8'h6c; 8'hb9: s=8'h56; 8'hba: s=8'hf4; 8'hbb: s=8'hea; 8'hbc: s=8'h65; 8'hbd: s=8'h7a; 8'hbe: s=8'hae; 8'hbf: s=8'h08;
      8'hc0: s=8'hba; 8'hc1: s=8'h78; 8'hc2: s=8'h25; 8'hc3: s=8'h2e; 8'hc4: s=8'h1c; 8'hc5: s=8'ha6; 8'hc6: s=8'hb4; 8'hc7: s=8'hc6;
      8'hc8: s=8'he8; 8'hc9: s=8'hdd; 8'hca: s=8'h74; 8'hcb: s=8'h1f; 8'hcc: s=8'h4b; 8'hcd: s=8'hbd; 8'hce: s=8'h8b; 8'hcf: s=8'h8a;
      8'hd0: s=8'h70; 8'hd1: s=8'h3e; 8'hd2: s=8'hb5; 8'hd3: s=8'h66; 8'hd4: s=8'h48; 8'hd5: s=8'h03; 8'hd6: s=8'hf6; 8'hd7: s=8'h0e;
      8'hd8: s=8'h61; 8'hd9: s=8'h35; 8'hda: s=8'h57; 8'hdb: s=8'hb9; 8'hdc: s=8'h86; 8'hdd: s=8'hc1; 8'hde: s=8'h1d; 8'hdf: s=8'h9e;
      8'he0: s=8'he1; 8'he1: s=8'hf8; 8'he2: s=8'h98; 8'he3: s=8'h11; 8'he4: s=8'h69; 8'he5: s=8'hd9; 8'he6: s=8'h8e; 8'he7: s=8'h94;
      8'he8: s=8'h9b; 8'he9: s=8'h1e; 8'hea: s=8'h87; 8'heb: s=8'he9; 8'hec: s=8'hce; 8'hed: s=8'h55; 8'hee: s=8'h28; 8'hef: s=8'hdf;
      8'hf0: s=8'h8c; 8'hf1: s=8'ha1; 8'hf2: s=8'h89; 8'hf3: s=8'h0d; 8'hf4: s=8'hbf; 8'hf5: s=8'he6; 8'hf6: s=8'h42; 8'hf7: s=8'h68;
      8'hf8: s=8'h41; 8'hf9: s=8'h99; 8'hfa: s=8'h2d; 8'hfb: s=8'h0f; 8'hfc: s=8'hb0; 8'hfd: s=8'h54; 8'hfe: s=8'hbb; 8'hff: s=8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox(i_byte);

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register file that the round datapaths read combinationally by index.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [0:KEY_W-1] key,
  output logic             busy,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [0:KEY_W-1] rd_key
);

  if (NR != 10 || KEY_W != 128) begin : g_unsupported
    $error("aes_key_expander supports only NR=10 and KEY_W=128");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_round;
  logic [0:KEY_W-1] r_rk [0:NR];
  logic             w_rk_we;
  logic [3:0]       w_prev_idx;
  logic [0:KEY_W-1] w_prev;
  logic [0:KEY_W-1] w_next;
  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [31:0]      w_t;
  logic [31:0]      w_w0n;
  logic [31:0]      w_w1n;
  logic [31:0]      w_w2n;
  logic [31:0]      w_w3n;

  // State register; round saturates at NR so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_round <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (start)
        r_round <= 4'd1;
      else if (r_state == ST_EXPAND && r_round != 4'(NR))
        r_round <= r_round + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_EXPAND;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_IDLE;
        ST_EXPAND: if (r_round == 4'(NR)) w_state_nxt = ST_DONE;
        ST_DONE:   w_state_nxt = ST_DONE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state == ST_EXPAND);
    keys_valid = (r_state == ST_DONE);
    w_rk_we    = (r_state == ST_EXPAND) && !start;
  end

  assign w_prev_idx = r_round - 4'd1;

  always_comb begin
    w_prev = '0;
    for (int i = 0; i <= NR; i++)
      if (w_prev_idx == 4'(i)) w_prev = r_rk[i];
  end

  assign w_rot = rot_word(w_prev[96:127]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(w_rot[8*g +: 8]),
      .o_byte(w_sub[8*g +: 8])
    );
  end

  assign w_t    = w_sub ^ {rcon(r_round), 24'h0};
  assign w_w0n  = w_prev[0:31]  ^ w_t;
  assign w_w1n  = w_prev[32:63] ^ w_w0n;
  assign w_w2n  = w_prev[64:95] ^ w_w1n;
  assign w_w3n  = w_prev[96:127] ^ w_w2n;
  assign w_next = {w_w0n, w_w1n, w_w2n, w_w3n};

  // Single write port: entry 0 takes the cipher key, entry r_round the next key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (start && i == 0)
          r_rk[i] <= key;
        else if (w_rk_we && r_round == 4'(i))
          r_rk[i] <= w_next;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++)
      if (rd_idx == 4'(i)) rd_key = r_rk[i];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for the AES-128 key schedule using FIPS-197 key vectors.
module tb_aes_key_expander;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [0:127] key;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [0:127] rd_key;

  int n_checks;
  int n_errors;

  logic [127:0] vec1_key;
  logic [127:0] vec1 [0:10];
  logic [127:0] zero_rk1;
  logic [127:0] zero_rk10;

  aes_key_expander dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .key(key),
    .busy(busy),
    .keys_valid(keys_valid),
    .rd_idx(rd_idx),
    .rd_key(rd_key)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input int idx, output logic [127:0] val);
    rd_idx = 4'(idx);
    #1;
    val = rd_key;
  endtask

  task automatic start_edge(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called just after the final start edge: valid must appear exactly at E10.
  task automatic expect_done_after_10(input string tag);
    for (int i = 1; i < 10; i++) begin
      tick();
      check({tag, "_kv_low"}, {127'b0, keys_valid}, 128'd0);
      check({tag, "_busy_high"}, {127'b0, busy}, 128'd1);
    end
    tick();
    check({tag, "_kv_at_E10"}, {127'b0, keys_valid}, 128'd1);
    check({tag, "_busy_at_E10"}, {127'b0, busy}, 128'd0);
  endtask

  task automatic check_vec1(input string tag);
    logic [127:0] v;
    for (int i = 0; i <= 10; i++) begin
      read_key(i, v);
      check($sformatf("%s_rk%0d", tag, i), v, vec1[i]);
    end
  endtask

  initial begin
    logic [127:0] v;
    n_checks = 0;
    n_errors = 0;
    vec1_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vec1[0]   = vec1_key;
    vec1[1]   = 128'ha0fafe1788542cb123a339392a6c7605;
    vec1[2]   = 128'hf2c295f27a96b9435935807a7359f67f;
    vec1[3]   = 128'h3d80477d4716fe3e1e237e446d7a883b;
    vec1[4]   = 128'hef44a541a8525b7fb671253bdb0bad00;
    vec1[5]   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    vec1[6]   = 128'h6d88a37a110b3efddbf98641ca0093fd;
    vec1[7]   = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    vec1[8]   = 128'head27321b58dbad2312bf5607f8d292f;
    vec1[9]   = 128'hac7766f319fadc2128d12941575c006e;
    vec1[10]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk1  = 128'h62636363626363636263636362636363;
    zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    reset_n = 1'b0;
    start   = 1'b0;
    key     = '0;
    rd_idx  = 4'd0;
    #20;
    check("reset_busy", {127'b0, busy}, 128'd0);
    check("reset_kv", {127'b0, keys_valid}, 128'd0);
    check("reset_rk0", rd_key, 128'd0);
    #30 reset_n = 1'b1;
    tick();
    tick();
    check("idle_kv", {127'b0, keys_valid}, 128'd0);

    // Vector 1
    start_edge(vec1_key);
    check("v1_busy_E0", {127'b0, busy}, 128'd1);
    expect_done_after_10("v1");
    check_vec1("v1");

    // Key changes without start leave the schedule frozen
    key = 128'h00112233445566778899aabbccddeeff;
    tick(); tick(); tick();
    check("hold_busy", {127'b0, busy}, 128'd0);
    check("hold_kv", {127'b0, keys_valid}, 128'd1);
    check_vec1("hold");
    for (int i = 11; i <= 15; i++) begin
      read_key(i, v);
      check($sformatf("oob_idx%0d", i), v, 128'd0);
    end

    // Zero key, started from DONE: valid drops at the start edge
    start_edge(128'd0);
    check("zero_kv_drop", {127'b0, keys_valid}, 128'd0);
    expect_done_after_10("zero");
    read_key(0, v);  check("zero_rk0", v, 128'd0);
    read_key(1, v);  check("zero_rk1", v, zero_rk1);
    read_key(10, v); check("zero_rk10", v, zero_rk10);

    // Restart with the zero key at E4 of a vector-1 expansion
    start_edge(vec1_key);
    tick(); tick(); tick();
    check("rs_kv_mid", {127'b0, keys_valid}, 128'd0);
    start_edge(128'd0);
    expect_done_after_10("rs");
    read_key(1, v);  check("rs_rk1", v, zero_rk1);
    read_key(10, v); check("rs_rk10", v, zero_rk10);

    // Asynchronous reset at E5
    start_edge(vec1_key);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", {127'b0, busy}, 128'd1);
    reset_n = 1'b0;
    #1;
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_kv", {127'b0, keys_valid}, 128'd0);
    for (int i = 0; i <= 10; i++) begin
      read_key(i, v);
      check($sformatf("rst_rk%0d", i), v, 128'd0);
    end
    #10 reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", {127'b0, busy}, 128'd0);
    check("post_rst_kv", {127'b0, keys_valid}, 128'd0);
    start_edge(vec1_key);
    expect_done_after_10("after_rst");
    check_vec1("after_rst");

    // Start held for three edges; the last edge carries vector 1
    key   = '0;
    start = 1'b1;
    tick();
    check("held_busy1", {127'b0, busy}, 128'd1);
    tick();
    check("held_kv2", {127'b0, keys_valid}, 128'd0);
    key = vec1_key;
    tick();
    start = 1'b0;
    expect_done_after_10("held");
    check_vec1("held");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
